// File: rtl/alu_seq_pkg.sv
// Shared constants for alu_sequencer: default widths and FSM state encodings.
package alu_seq_pkg;

  localparam int NB_IN_DEF       = 8;
  localparam int NB_OUT_DEF      = 8;
  localparam int NB_CODE_DEF     = 6;
  localparam int DEBOUNCE_DEF    = 16;

  localparam logic [2:0] S_DATO1 = 3'b000;
  localparam logic [2:0] S_DATO2 = 3'b001;
  localparam logic [2:0] S_CODE  = 3'b010;
  localparam logic [2:0] S_EXEC  = 3'b011;
  localparam logic [2:0] S_SHOW  = 3'b100;

endpackage

// File: rtl/button_conditioner.sv
// Push-button conditioner: 2-flop synchronizer, optional debounce filter
// (enabled by macro ALU_SEQUENCER_DEBOUNCE_EN), rising-edge press pulse.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic press_o
);

`ifdef ALU_SEQUENCER_DEBOUNCE_EN
  localparam bit DB_EN = 1'b1;
`else
  localparam bit DB_EN = 1'b0;
`endif

  logic sync1_q, sync2_q, prev_q;
  logic level;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      prev_q  <= level;
    end
  end

  generate
    if (DB_EN && DEBOUNCE_CYCLES > 0) begin : g_db
      localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
      localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
      logic          stable_q;
      logic [CW-1:0] cnt_q;

      // cnt_q counts consecutive samples that disagree with the accepted level
      always_ff @(posedge clk) begin
        if (reset) begin
          stable_q <= 1'b0;
          cnt_q    <= '0;
        end else if (sync2_q != stable_q) begin
          if (cnt_q == CNT_MAX) begin
            stable_q <= sync2_q;
            cnt_q    <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end else begin
          cnt_q <= '0;
        end
      end

      assign level = stable_q;
    end else begin : g_nodb
      assign level = sync2_q;
    end
  endgenerate

  assign press_o = level & ~prev_q;

endmodule

// File: rtl/alu_sequencer.sv
// Front-panel sequencer for an external ALU: two operands and an op-code are
// entered from switches, the result is latched and shown. Debounce is enabled
// with macro ALU_SEQUENCER_DEBOUNCE_EN.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int NB_IN           = NB_IN_DEF,
  parameter int NB_OUT          = NB_OUT_DEF,
  parameter int NB_CODE         = NB_CODE_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NB_IN-1:0]   switch,
  input  logic               b_next,
  input  logic               b_clear,
  input  logic [NB_OUT-1:0]  alu_result,
  output logic [NB_IN-1:0]   dato1,
  output logic [NB_IN-1:0]   dato2,
  output logic [NB_CODE-1:0] op_code,
  output logic [NB_OUT-1:0]  result,
  output logic               result_valid,
  output logic [2:0]         state
);

  logic next_ev, clear_ev;

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
    .clk(clk), .reset(reset), .btn_i(b_next), .press_o(next_ev)
  );

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
    .clk(clk), .reset(reset), .btn_i(b_clear), .press_o(clear_ev)
  );

  logic [2:0]         state_q,   state_d;
  logic [NB_IN-1:0]   dato1_q,   dato1_d;
  logic [NB_IN-1:0]   dato2_q,   dato2_d;
  logic [NB_CODE-1:0] op_code_q, op_code_d;
  logic [NB_OUT-1:0]  result_q,  result_d;
  logic               valid_q,   valid_d;

  always_comb begin
    state_d   = state_q;
    dato1_d   = dato1_q;
    dato2_d   = dato2_q;
    op_code_d = op_code_q;
    result_d  = result_q;
    valid_d   = valid_q;
    // Clear wins over next and over the S_EXEC latch
    if (clear_ev) begin
      state_d   = S_DATO1;
      dato1_d   = '0;
      dato2_d   = '0;
      op_code_d = '0;
      result_d  = '0;
      valid_d   = 1'b0;
    end else begin
      case (state_q)
        S_DATO1: if (next_ev) begin
          dato1_d = switch;
          state_d = S_DATO2;
        end
        S_DATO2: if (next_ev) begin
          dato2_d = switch;
          state_d = S_CODE;
        end
        S_CODE: if (next_ev) begin
          op_code_d = switch[NB_CODE-1:0];
          state_d   = S_EXEC;
        end
        S_EXEC: begin
          result_d = alu_result;
          valid_d  = 1'b1;
          state_d  = S_SHOW;
        end
        S_SHOW: if (next_ev) begin
          valid_d = 1'b0;
          state_d = S_DATO1;
        end
        default: state_d = S_DATO1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_DATO1;
      dato1_q   <= '0;
      dato2_q   <= '0;
      op_code_q <= '0;
      result_q  <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      dato1_q   <= dato1_d;
      dato2_q   <= dato2_d;
      op_code_q <= op_code_d;
      result_q  <= result_d;
      valid_q   <= valid_d;
    end
  end

  assign dato1        = dato1_q;
  assign dato2        = dato2_q;
  assign op_code      = op_code_q;
  assign result       = result_q;
  assign result_valid = valid_q;
  assign state        = state_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized bench for alu_sequencer with a transaction-level model of the
// front panel; honours ALU_SEQUENCER_DEBOUNCE_EN for press latency.
module tb_alu_sequencer;

  localparam int DEB = 16;
`ifdef ALU_SEQUENCER_DEBOUNCE_EN
  localparam int LAT      = DEB + 3;
  localparam int MIN_HOLD = DEB;
`else
  localparam int LAT      = 3;
  localparam int MIN_HOLD = 1;
`endif

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [7:0] switch;
  logic       b_next, b_clear;
  logic [7:0] alu_result;
  logic [7:0] dato1, dato2, result;
  logic [5:0] op_code;
  logic       result_valid;
  logic [2:0] state;

  assign alu_result = dato1 + dato2;

  alu_sequencer #(
    .NB_IN(8), .NB_OUT(8), .NB_CODE(6), .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk), .reset(reset), .switch(switch), .b_next(b_next),
    .b_clear(b_clear), .alu_result(alu_result), .dato1(dato1),
    .dato2(dato2), .op_code(op_code), .result(result),
    .result_valid(result_valid), .state(state)
  );

  // reference model: panel step plus entered values
  localparam int P_D1 = 0, P_D2 = 1, P_CODE = 2, P_EXEC = 3, P_SHOW = 4;
  int         m_phase;
  logic [7:0] m_d1, m_d2, m_res;
  logic [5:0] m_code;
  logic       m_valid;
  logic       seen_valid;
  logic [7:0] exp_q[$];

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_zero();
    m_phase = P_D1;
    m_d1 = '0; m_d2 = '0; m_code = '0; m_res = '0; m_valid = 1'b0;
  endtask

  task automatic model_edge(input bit ev_n, input bit ev_c, input bit rst);
    if (rst || ev_c) model_zero();
    else begin
      case (m_phase)
        P_D1:   if (ev_n) begin m_d1 = switch; m_phase = P_D2; end
        P_D2:   if (ev_n) begin m_d2 = switch; m_phase = P_CODE; end
        P_CODE: if (ev_n) begin m_code = switch[5:0]; m_phase = P_EXEC; end
        P_EXEC: begin
          m_res = 8'((int'(m_d1) + int'(m_d2)) % 256);
          m_valid = 1'b1;
          m_phase = P_SHOW;
          exp_q.push_back(m_res);
        end
        default: if (ev_n) begin m_valid = 1'b0; m_phase = P_D1; end
      endcase
    end
  endtask

  task automatic compare_all();
    check("state", 32'(state), 32'(m_phase));
    check("dato1", 32'(dato1), 32'(m_d1));
    check("dato2", 32'(dato2), 32'(m_d2));
    check("op_code", 32'(op_code), 32'(m_code));
    check("result", 32'(result), 32'(m_res));
    check("valid", 32'(result_valid), 32'(m_valid));
    if (result_valid === 1'b1 && !seen_valid) begin
      if (exp_q.size() == 0) check("res_q_empty", 32'd1, 32'd0);
      else check("res_q", 32'(result), 32'(exp_q.pop_front()));
    end
    seen_valid = (result_valid === 1'b1);
  endtask

  // driver: caller is at a negedge; edge i is the i-th edge after driving
  task automatic press(input bit do_n, input bit do_c, input int hold,
                       input logic [7:0] sw, input bit rst_exec);
    switch = sw; b_next = do_n; b_clear = do_c;
    for (int i = 1; i <= hold + LAT + 2; i++) begin
      @(negedge clk);
      model_edge(do_n && hold >= MIN_HOLD && i == LAT,
                 do_c && hold >= MIN_HOLD && i == LAT,
                 rst_exec && i == LAT + 1);
      compare_all();
      if (i == hold) begin b_next = 1'b0; b_clear = 1'b0; end
      if (rst_exec && i == LAT) begin reset = 1'b1; b_next = 1'b0; b_clear = 1'b0; end
      if (rst_exec && i == LAT + 1) reset = 1'b0;
    end
  endtask

  localparam int H = MIN_HOLD + 4;

  initial begin
    reset = 1'b1; switch = '0; b_next = 1'b0; b_clear = 1'b0;
    seen_valid = 1'b0;
    model_zero();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    compare_all();

    // basic add sequence
    press(1, 0, H, 8'h05, 0);
    press(1, 0, H, 8'h03, 0);
    press(1, 0, H, 8'h20, 0);
    check("seq_dato1", 32'(dato1), 32'h05);
    check("seq_dato2", 32'(dato2), 32'h03);
    check("seq_code", 32'(op_code), 32'h20);
    check("seq_result", 32'(result), 32'h08);
    check("seq_valid", 32'(result_valid), 32'd1);
    check("seq_state", 32'(state), 32'd4);

    // back to S_DATO1, then a long hold yields one step
    press(1, 0, H, 8'h00, 0);
    press(1, 0, 50, 8'h77, 0);
    check("hold_state", 32'(state), 32'd1);

    // clear in S_CODE
    press(0, 1, H, 8'h00, 0);
    press(1, 0, H, 8'hAA, 0);
    press(1, 0, H, 8'h11, 0);
    press(0, 1, H, 8'h00, 0);
    check("clr_dato1", 32'(dato1), 32'd0);
    check("clr_state", 32'(state), 32'd0);
    check("clr_valid", 32'(result_valid), 32'd0);

    // simultaneous next and clear in S_DATO2
    press(1, 0, H, 8'h12, 0);
    press(1, 1, H, 8'h34, 0);
    check("both_state", 32'(state), 32'd0);
    check("both_dato2", 32'(dato2), 32'd0);

    // reset during S_EXEC
    press(1, 0, H, 8'h40, 0);
    press(1, 0, H, 8'h41, 0);
    press(1, 0, LAT, 8'h05, 1);
    check("rst_result", 32'(result), 32'd0);
    check("rst_valid", 32'(result_valid), 32'd0);
    check("rst_state", 32'(state), 32'd0);

    // short glitch and a 20-cycle press
    press(1, 0, 10, 8'h66, 0);
    press(1, 0, 20, 8'h67, 0);

    // random presses
    for (int k = 0; k < 60; k++) begin
      int r;
      r = $urandom_range(0, 9);
      press(r >= 2, r <= 1, $urandom_range(1, MIN_HOLD + 6), 8'($urandom), 0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
